// File: rtl/avg_result_sink.sv
// avg_result_sink: result-side sink for the three-operand averaging pipeline.
// Tracks in-flight launches, captures each avg into a FIFO, serves it ready/valid.
module avg_result_sink #(
    parameter int WIDTH = 8,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         avg_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [LAT-1:0]   r_vsr;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [15:0]      r_count;
    logic             r_overflow;

    logic [AW:0]      w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Occupancy comes from the pointer difference; the extra wrap bit
    // separates full from empty when the index bits coincide.
    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_req = r_vsr[LAT-1];
    assign w_pop      = !w_empty && out_ready;
    // A pop on the same edge frees the slot the push will land in.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign out_valid  = !w_empty;
    assign out_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign level      = w_level;
    assign count      = r_count;
    assign overflow   = r_overflow;

    // Launch tags travel alongside the operands through the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsr <= '0;
        end else begin
            r_vsr[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                r_vsr[i] <= r_vsr[i-1];
            end
        end
    end

    // FIFO storage: capture avg_in at the write pointer on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= avg_in;
        end
    end

    // Write pointer advances once per accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Read pointer advances once per downstream transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Accepted-result counter, pinned at all-ones once it gets there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_push && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Sticky drop indicator; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avg_result_sink.sv
// tb_avg_result_sink: scoreboard bench for avg_result_sink.
// Model: averager launches keyed by edge number, FIFO as a plain occupancy count.
module tb_avg_result_sink;

    localparam int WIDTH = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] avg_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;
    logic [15:0]      count;
    logic             overflow;

    avg_result_sink #(
        .WIDTH (WIDTH),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .avg_in    (avg_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    int launched [int];
    int sb [$];
    int m_level = 0;
    int m_count = 0;
    int m_ovf   = 0;
    int e       = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next edge; compare with scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0d expected no data", out_data);
            end else begin
                chk("pop_data", int'(out_data), sb.pop_front());
            end
        end
    end

    task automatic model_edge(input int n, input logic rdy);
        int v;
        if (m_level > 0 && rdy) m_level--;
        if (launched.exists(n - LAT)) begin
            v = launched[n - LAT];
            launched.delete(n - LAT);
            if (m_level < DEPTH) begin
                m_level++;
                if (m_count < 65535) m_count++;
                sb.push_back(v);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_state();
        chk("out_valid", int'(out_valid), int'(m_level != 0));
        chk("level", int'(level), m_level);
        chk("count", int'(count), m_count);
        chk("overflow", int'(overflow), m_ovf);
        if (m_level != 0 && sb.size() != 0)
            chk("head_data", int'(out_data), sb[0]);
    endtask

    // One clock cycle: apply inputs, take the edge, update model, check.
    task automatic step(input logic iv, input int a, input int b,
                        input int c, input logic rdy);
        int n;
        n = e + 1;
        in_valid  = iv;
        out_ready = rdy;
        if (iv) launched[n] = (a + b + c) / 3;
        if (launched.exists(n - LAT)) avg_in = WIDTH'(launched[n - LAT]);
        else avg_in = WIDTH'($urandom);
        @(posedge clk);
        e = n;
        #1;
        if (!rst) begin
            model_edge(n, rdy);
            check_state();
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, rdy);
    endtask

    // Asynchronous reset asserted between edges, checked before any edge.
    task automatic do_reset();
        #3;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_level   = 0;
        m_count   = 0;
        m_ovf     = 0;
        sb.delete();
        launched.delete();
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(posedge clk);
        e++;
        @(posedge clk);
        e++;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int a;
        int b;
        int c;
        int pr;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        avg_in    = '0;
        #1;
        chk("init_out_valid", int'(out_valid), 0);
        chk("init_out_data", int'(out_data), 0);
        chk("init_level", int'(level), 0);
        chk("init_count", int'(count), 0);
        chk("init_overflow", int'(overflow), 0);
        @(posedge clk);
        e++;
        @(posedge clk);
        e++;
        #3;
        rst = 1'b0;

        // Latency: single launch, result visible after LAT edges.
        step(1'b1, 3, 6, 9, 1'b0);
        idle(LAT - 1, 1'b0);
        chk("lat_not_yet", int'(out_valid), 0);
        idle(1, 1'b0);
        chk("lat_data", int'(out_data), 6);
        chk("lat_level", int'(level), 1);
        idle(2, 1'b1);

        // Ordering: three consecutive launches then drain.
        step(1'b1, 3, 6, 9, 1'b0);
        step(1'b1, 4, 8, 12, 1'b0);
        step(1'b1, 9, 9, 9, 1'b0);
        idle(LAT + 1, 1'b0);
        chk("ord_level", int'(level), 3);
        idle(4, 1'b1);

        // Overflow: six launches into a stalled four-entry FIFO.
        for (int i = 0; i < 6; i++) step(1'b1, 9, 9, 9, 1'b0);
        idle(LAT + 1, 1'b0);
        chk("ovf_level", int'(level), DEPTH);
        chk("ovf_flag", int'(overflow), 1);
        idle(1, 1'b1);
        chk("ovf_sticky", int'(overflow), 1);
        idle(DEPTH + 2, 1'b1);

        // Full boundary: push and pop on the same edge while full.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, i, 10 * i, 2 * i, 1'b0);
        step(1'b1, 50, 60, 70, 1'b0);
        idle(LAT - 1, 1'b0);
        chk("full_pre", int'(level), DEPTH);
        idle(1, 1'b1);
        chk("full_level", int'(level), DEPTH);
        chk("full_count", int'(count), DEPTH + 1);
        chk("full_ovf", int'(overflow), 0);
        idle(DEPTH + 2, 1'b1);

        // Mid-stream reset with two tags in flight and two entries stored.
        for (int i = 0; i < 4; i++) step(1'b1, 7, 8, 9, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);
        chk("mid_pre_level", int'(level), 2);
        do_reset();
        idle(LAT + 1, 1'b0);

        // Random traffic, low then high downstream readiness.
        for (int i = 0; i < 600; i++) begin
            pr = (i < 200) ? 30 : 85;
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            c  = $urandom_range(0, 255);
            if (i == 350) do_reset();
            step(1'($urandom_range(0, 99) < 60), a, b, c,
                 1'($urandom_range(0, 99) < pr));
        end

        idle(DEPTH + LAT + 4, 1'b1);
        chk("drain_empty", sb.size(), 0);
        chk("drain_level", int'(level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
